// File: rtl/spi_pkg.sv
// Shared definitions for the parallel-lane SPI link (host and device sides).
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    SKIP = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word; the head register is refreshed
// on a pop or on a write into an empty buffer, so there is no comb bypass.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           rd_ptr_nxt;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign rd_ptr_nxt = rd_ptr + PTR_ONE;
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
    end
  end

  // With one word left, the next head can only be the word arriving this cycle.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_data <= '0;
    end else if (do_push && empty) begin
      rd_data <= wr_data;
    end else if (do_pop) begin
      if (count == PTR_ONE) begin
        if (do_push) rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/spi_device_rx.sv
// Receive side of the parallel-lane SPI link: synchronizes the host bundle,
// captures one word per SPI clock rise into a FIFO and reports frame status.
//
// state | meaning
// SKIP  | after reset; wait for select high so a partial frame is not captured
// IDLE  | between frames; select low starts a new frame
// RECV  | frame in progress; words captured on each SPI clock rise
module spi_device_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  spi_clk_in,
  input  logic                  spi_sel_in,
  input  logic [DATA_WIDTH-1:0] spi_data_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic                  s1_clk, s2_clk, s3_clk;
  logic                  s1_sel, s2_sel, s3_sel;
  logic [DATA_WIDTH-1:0] s1_data, s2_data;
  logic [1:0]            primed;
  logic                  rise;
  logic                  capture;
  logic                  frame_start;
  logic                  frame_end;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LEN_WIDTH-1:0]  word_cnt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1_clk  <= 1'b0;
      s2_clk  <= 1'b0;
      s3_clk  <= 1'b0;
      s1_sel  <= 1'b1;
      s2_sel  <= 1'b1;
      s3_sel  <= 1'b1;
      s1_data <= '0;
      s2_data <= '0;
    end else begin
      s1_clk  <= spi_clk_in;
      s2_clk  <= s1_clk;
      s3_clk  <= s2_clk;
      s1_sel  <= spi_sel_in;
      s2_sel  <= s1_sel;
      s3_sel  <= s2_sel;
      s1_data <= spi_data_in;
      s2_data <= s1_data;
    end
  end

  // The synchronizer resets to select-high; SKIP must not trust that value,
  // so it waits until s2 holds a genuine sample of the pin.
  always_ff @(posedge clk) begin
    if (!nrst) primed <= 2'b00;
    else       primed <= {primed[0], 1'b1};
  end

  assign rise = s2_clk && !s3_clk && !s2_sel;

  always_ff @(posedge clk) begin
    if (!nrst) state <= SKIP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SKIP:    if (primed[1] && s2_sel && s3_sel) state_nxt = IDLE;
      IDLE:    if (!s2_sel) state_nxt = RECV;
      RECV:    if (s2_sel)  state_nxt = IDLE;
      default: state_nxt = SKIP;
    endcase
  end

  always_comb begin
    busy        = (state == RECV);
    capture     = (state == RECV) && rise;
    frame_start = (state == IDLE) && !s2_sel;
    frame_end   = (state == RECV) && s2_sel;
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (capture),
    .wr_data (s2_data),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd_data (out_data)
  );

  // Dropped words still count: frame_len reflects what was on the wire.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      word_cnt   <= '0;
      overflow   <= 1'b0;
      frame_len  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_start) begin
        word_cnt  <= '0;
        overflow  <= 1'b0;
        frame_len <= '0;
      end else begin
        if (capture && word_cnt != LEN_MAX) word_cnt <= word_cnt + LEN_ONE;
        if (capture && fifo_full && !pop)   overflow <= 1'b1;
        if (frame_end)                      frame_len <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_spi_device_rx.sv
// Scoreboard bench for spi_device_rx: directed host frames, queued expectations
// checked by an independent monitor whenever a word or frame result appears.
module tb_spi_device_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 8;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          spi_clk_in = 1'b0;
  logic          spi_sel_in = 1'b1;
  logic [DW-1:0] spi_data_in = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;
  logic [LW-1:0] frame_len;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_data[$];
  int exp_len[$];
  int exp_ovf[$];

  spi_device_rx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .spi_clk_in  (spi_clk_in),
    .spi_sel_in  (spi_sel_in),
    .spi_data_in (spi_data_in),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    spi_sel_in = 1'b0;
    cyc(4);
  endtask

  task automatic frame_end(input int gap);
    cyc(3);
    spi_sel_in = 1'b1;
    cyc(gap);
  endtask

  task automatic send_word(input int v);
    spi_data_in = v[DW-1:0];
    cyc(2);
    spi_clk_in = 1'b1;
    cyc(3);
    spi_clk_in = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input int max_cyc);
    out_ready = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_data.size() == 0) break;
      cyc(1);
    end
    check("drain_remaining", exp_data.size(), 0);
    cyc(2);
    check("empty_after_drain", int'(out_valid), 0);
  endtask

  // Monitor: compares every accepted word and every frame report.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %0h, expected none", out_data);
        end else begin
          check("out_data", int'(out_data), exp_data.pop_front());
        end
      end
      if (frame_done) begin
        if (exp_len.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame_done: got len %0d, expected none", frame_len);
        end else begin
          check("frame_len", int'(frame_len), exp_len.pop_front());
          check("frame_overflow", int'(overflow), exp_ovf.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(3);
    nrst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_len", int'(frame_len), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    cyc(8);

    // Single frame 1..14 with consumer always ready
    out_ready = 1'b1;
    frame_begin();
    check("busy_in_frame", int'(busy), 1);
    for (int v = 1; v <= 14; v++) begin
      exp_data.push_back(v);
      send_word(v);
    end
    exp_len.push_back(14); exp_ovf.push_back(0);
    frame_end(8);
    check("frame_len_hold", int'(frame_len), 14);
    check("busy_after_frame", int'(busy), 0);
    drain(50);

    // Backpressure: 20 words into a 16-deep FIFO
    out_ready = 1'b0;
    frame_begin();
    for (int v = 1; v <= 20; v++) begin
      if (v <= DEPTH) exp_data.push_back(v);
      send_word(v);
    end
    exp_len.push_back(20); exp_ovf.push_back(1);
    frame_end(8);
    check("overflow_sticky", int'(overflow), 1);
    drain(100);

    // Full FIFO with a pop in the same cycle as the rise
    out_ready = 1'b0;
    frame_begin();
    check("overflow_cleared", int'(overflow), 0);
    for (int v = 'h21; v <= 'h30; v++) begin
      exp_data.push_back(v);
      send_word(v);
    end
    exp_data.push_back('h31);
    spi_data_in = 8'h31;
    cyc(2);
    spi_clk_in = 1'b1;
    cyc(2);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(1);
    spi_clk_in = 1'b0;
    cyc(1);
    check("full_pop_valid", int'(out_valid), 1);
    check("full_pop_head", int'(out_data), 'h22);
    exp_len.push_back(17); exp_ovf.push_back(0);
    frame_end(8);
    check("full_pop_no_overflow", int'(overflow), 0);
    drain(100);

    // Latency: one edge into an empty FIFO
    out_ready = 1'b0;
    frame_begin();
    spi_data_in = 8'h5A;
    cyc(2);
    spi_clk_in = 1'b1;
    cyc(2);
    @(negedge clk);
    check("lat_before_k2", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_after_k2", int'(out_valid), 1);
    check("lat_data", int'(out_data), 'h5A);
    cyc(1);
    spi_clk_in = 1'b0;
    cyc(1);
    exp_data.push_back('h5A);
    exp_len.push_back(1); exp_ovf.push_back(0);
    frame_end(8);
    drain(20);

    // Reset in the middle of a frame
    out_ready = 1'b0;
    frame_begin();
    for (int v = 'h41; v <= 'h45; v++) send_word(v);
    check("pre_reset_valid", int'(out_valid), 1);
    nrst = 1'b0;
    cyc(2);
    nrst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    for (int v = 'h46; v <= 'h48; v++) send_word(v);
    check("ignored_after_reset", int'(out_valid), 0);
    check("skip_not_busy", int'(busy), 0);
    frame_end(8);
    out_ready = 1'b1;
    frame_begin();
    for (int v = 'h61; v <= 'h63; v++) begin
      exp_data.push_back(v);
      send_word(v);
    end
    exp_len.push_back(3); exp_ovf.push_back(0);
    frame_end(8);
    drain(20);

    // Back-to-back frames with a 2-cycle select-high gap
    out_ready = 1'b1;
    frame_begin();
    for (int v = 'h71; v <= 'h74; v++) begin
      exp_data.push_back(v);
      send_word(v);
    end
    exp_len.push_back(4); exp_ovf.push_back(0);
    frame_end(2);
    frame_begin();
    for (int v = 'h75; v <= 'h7A; v++) begin
      exp_data.push_back(v);
      send_word(v);
    end
    exp_len.push_back(6); exp_ovf.push_back(0);
    frame_end(8);
    drain(20);

    for (int i = 0; i < 20; i++) begin
      if (exp_len.size() == 0) break;
      cyc(1);
    end
    check("frames_pending", exp_len.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
